// File: rtl/instruction_loader.sv
// instruction_loader: receives a framed byte stream (HEADER, start address,
// length N, N data bytes and, optionally, an XOR checksum byte) and writes
// the data bytes into a 128-byte instruction memory while holding the CPU.
//
// Build option: define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte after the data. Without it the frame ends after the last
// data byte and the only error source is an illegal length.
module instruction_loader #(
   parameter int         MEM_DEPTH = 128,
   parameter logic [7:0] HEADER    = 8'hA5
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] InData,
   input  logic       InValid,
   output logic       InReady,
   output logic       WrEn,
   output logic [6:0] WrAddr,
   output logic [7:0] WrData,
   output logic       CpuHold,
   output logic       Done,
   output logic       ErrorFlag
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } state_t;

   // Largest legal length, widened so 8-bit counts above it compare correctly.
   localparam logic [8:0] MAX_LEN = 9'(MEM_DEPTH);

   state_t     state;
   state_t     state_nxt;
   logic [6:0] addr;
   logic [7:0] count;
   logic       accept;
   logic       len_bad;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   assign InReady = (state != S_DONE) && (state != S_ERR);
   assign accept  = InValid && InReady;
   assign len_bad = (InData == 8'd0) || ({1'b0, InData} > MAX_LEN);
   assign CpuHold = (state != S_IDLE);
   assign Done    = (state == S_DONE);

   // State register; reset abandons any frame in progress.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode: frame parsing advances only on accepted bytes.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && (InData == HEADER)) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (accept) state_nxt = S_LEN;
         end
         S_LEN: begin
            if (accept) state_nxt = len_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            if (accept && (count == 8'd1)) state_nxt = S_CHK;
`else
            if (accept && (count == 8'd1)) state_nxt = S_DONE;
`endif
         end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) state_nxt = (InData == csum) ? S_DONE : S_ERR;
         end
`endif
         S_DONE:  state_nxt = S_IDLE;
         S_ERR:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame datapath: address/count/checksum tracking and the one-cycle write strobe.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         WrEn      <= 1'b0;
         WrAddr    <= 7'd0;
         WrData    <= 8'd0;
         ErrorFlag <= 1'b0;
         addr      <= 7'd0;
         count     <= 8'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
         csum      <= 8'd0;
`endif
      end else begin
         WrEn <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (InData == HEADER) begin
                     ErrorFlag <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                     csum      <= 8'd0;
`endif
                  end
               end
               S_ADDR: addr  <= InData[6:0];
               S_LEN:  count <= InData;
               S_DATA: begin
                  // Stage boundary: accepted byte becomes a registered memory write.
                  WrEn   <= 1'b1;
                  WrAddr <= addr;
                  WrData <= InData;
                  addr   <= addr + 7'd1;
                  count  <= count - 8'd1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                  csum   <= csum ^ InData;
`endif
               end
               default: ;
            endcase
         end
         // Sticky error: raised on entry to ERR, cleared only by the next header.
         if (state_nxt == S_ERR) ErrorFlag <= 1'b1;
      end
   end

endmodule
